// File: rtl/des_iter_ctrl.sv
// Iterative DES engine: one Feistel round per clock over a single shared
// s_box instance, with IP/FP permutations and an encrypt/decrypt key schedule.

// s_box: the eight DES substitution boxes, purely combinational.
module s_box (
    input  logic [47:0] pattern,
    output logic [31:0] value
);
    // Each entry is one box, 64 nibbles, index 0 leftmost (index = row*16 + col).
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Split into 6-bit groups; row = outer two bits, column = inner four bits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        value = '0;
        for (int i = 0; i < 8; i++) begin
            value[31-4*i -: 4] = 4'(SBOX[i] >> (4 * (63 - {pattern[47-6*i], pattern[42-6*i],
                                                         pattern[46-6*i -: 4]})));
        end
    end
endmodule

module des_iter_ctrl #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_decrypt,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy,
    output logic [3:0]  round_idx
);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    // Permutation tables in DES 1-based bit numbers (bit 1 = MSB).
    localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                                 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                                 57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                                 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                                 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                                 36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                                 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                  10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                  63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                  14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                  16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                  44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                                16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
                                28,29,30,31,32,1};
    localparam int P_T [32] = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                                2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};

    function automatic logic [63:0] ip(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[6'(64 - IP_T[j])];
        return y;
    endfunction

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[63-j] = x[6'(64 - FP_T[j])];
        return y;
    endfunction

    function automatic logic [55:0] pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int j = 0; j < 56; j++) y[55-j] = x[6'(64 - PC1_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[47-j] = x[6'(56 - PC2_T[j])];
        return y;
    endfunction

    function automatic logic [47:0] e_exp(input logic [31:0] x);
        logic [47:0] y;
        for (int j = 0; j < 48; j++) y[47-j] = x[5'(32 - E_T[j])];
        return y;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] y;
        for (int j = 0; j < 32; j++) y[31-j] = x[5'(32 - P_T[j])];
        return y;
    endfunction

    function automatic logic [27:0] rol28(input logic [27:0] x, input logic [1:0] s);
        case (s)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] ror28(input logic [27:0] x, input logic [1:0] s);
        case (s)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

    // Encrypt schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (left shifts).
    function automatic logic [1:0] enc_shift(input logic [3:0] n);
        return (n == 4'd0 || n == 4'd1 || n == 4'd8 || n == 4'd15) ? 2'd1 : 2'd2;
    endfunction

    // Decrypt schedule 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (right shifts, undoing encrypt).
    function automatic logic [1:0] dec_shift(input logic [3:0] n);
        if (n == 4'd0) return 2'd0;
        return (n == 4'd1 || n == 4'd8 || n == 4'd15) ? 2'd1 : 2'd2;
    endfunction

    state_t      state, state_nxt;
    logic [31:0] l, r, r_new, sbox_out;
    logic [27:0] c, d, c_use, d_use;
    logic [47:0] subkey, sbox_in;
    logic [3:0]  cnt;
    logic        mode, last;

    assign last = (cnt == 4'(ROUNDS - 1));

    // Key halves for this round: rotated left (encrypt) or right (decrypt).
    always_comb begin
        c_use = c;
        d_use = d;
        if (mode) begin
            c_use = ror28(c, dec_shift(cnt));
            d_use = ror28(d, dec_shift(cnt));
        end else begin
            c_use = rol28(c, enc_shift(cnt));
            d_use = rol28(d, enc_shift(cnt));
        end
    end

    assign subkey  = pc2({c_use, d_use});
    assign sbox_in = e_exp(r) ^ subkey;
    assign r_new   = l ^ p_perm(sbox_out);

    s_box u_s_box (
        .pattern (sbox_in),
        .value   (sbox_out)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake/status outputs decoded from the current state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        round_idx = 4'd0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ROUND;
            end
            ROUND: begin
                busy      = 1'b1;
                round_idx = cnt;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load on acceptance, one Feistel round per ROUND cycle, result on the last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l        <= '0;
            r        <= '0;
            c        <= '0;
            d        <= '0;
            mode     <= 1'b0;
            cnt      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        {l, r} <= ip(in_data);
                        {c, d} <= pc1(in_key);
                        mode   <= in_decrypt;
                        cnt    <= '0;
                    end
                end
                ROUND: begin
                    l   <= r;
                    r   <= r_new;
                    c   <= c_use;
                    d   <= d_use;
                    cnt <= last ? 4'd0 : cnt + 4'd1;
                    // Final swap: output is FP(R16 || L16).
                    if (last) out_data <= fp({r_new, r});
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_des_iter_ctrl.sv
// Self-checking bench for des_iter_ctrl: known-answer vectors, random blocks
// against a behavioural DES model, backpressure, input churn and mid-round reset.
module tb_des_iter_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_decrypt = 1'b0, out_ready = 1'b0;
    logic [63:0] in_data = '0, in_key = '0;
    logic        in_ready, out_valid, busy;
    logic [63:0] out_data;
    logic [3:0]  round_idx;

    always #5 clk = ~clk;

    des_iter_ctrl #(.ROUNDS(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_decrypt(in_decrypt), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .round_idx(round_idx)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural DES reference ----------------
    int ip_q[$]  = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6,
                     64,56,48,40,32,24,16,8, 57,49,41,33,25,17,9,1, 59,51,43,35,27,19,11,3,
                     61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    int pc1_q[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_q[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int p_q[$]   = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                     2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    int shifts [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
    logic [255:0] sb [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Generic table permutation: result occupies the low t.size() bits.
    function automatic logic [63:0] perm(input logic [63:0] x, input int in_w, input int t[$]);
        logic [63:0] y = '0;
        for (int i = 0; i < t.size(); i++) y[t.size()-1-i] = x[in_w - t[i]];
        return y;
    endfunction

    // Final permutation taken as the inverse of IP.
    function automatic logic [63:0] inv_ip(input logic [63:0] x);
        logic [63:0] y = '0;
        for (int i = 0; i < 64; i++) y[64 - ip_q[i]] = x[63-i];
        return y;
    endfunction

    function automatic logic [31:0] f_round(input logic [31:0] rr, input logic [47:0] k);
        logic [47:0] ex = '0;
        logic [47:0] x;
        logic [63:0] pw;
        logic [31:0] s = '0;
        logic [5:0]  six;
        int          row, col;
        // Expansion: group b copies DES bits 4b..4b+5 of R, wrapping 0->32 and 33->1.
        for (int b = 0; b < 8; b++)
            for (int j = 0; j < 6; j++)
                ex[47 - (6*b + j)] = rr[32 - ((4*b + j + 31) % 32 + 1)];
        x = ex ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47 - 6*b -: 6];
            row = 2 * int'(six[5]) + int'(six[0]);
            col = int'(six[4:1]);
            s[31 - 4*b -: 4] = sb[b][255 - 4*(row*16 + col) -: 4];
        end
        pw = perm({32'h0, s}, 32, p_q);
        return pw[31:0];
    endfunction

    // Full 16 subkeys built forward; decryption applies them in reverse order.
    function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] data,
                                              input logic dec);
        logic [63:0] k56 = perm(key, 64, pc1_q);
        logic [27:0] c = k56[55:28];
        logic [27:0] d = k56[27:0];
        logic [47:0] ks [16];
        logic [63:0] tmp, x;
        logic [31:0] l, r, t;
        for (int i = 0; i < 16; i++) begin
            c = 28'({c, c} >> (28 - shifts[i]));
            d = 28'({d, d} >> (28 - shifts[i]));
            tmp = perm({8'h0, c, d}, 56, pc2_q);
            ks[i] = tmp[47:0];
        end
        x = perm(data, 64, ip_q);
        l = x[63:32];
        r = x[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ f_round(r, dec ? ks[15-i] : ks[i]);
            l = t;
        end
        return inv_ip({r, l});
    endfunction

    // ---------------- one block through the DUT ----------------
    task automatic run_block(input logic [63:0] key, input logic [63:0] data, input logic dec,
                             input logic [63:0] want, input string name, input bit churn,
                             input int hold);
        int edges = 0;
        bit idx_ok = 1'b1;
        check({name, " in_ready before"}, in_ready, 1);
        in_valid = 1'b1; in_key = key; in_data = data; in_decrypt = dec;
        tick();
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && edges < 40) begin
            if (busy !== 1'b1 || round_idx !== edges[3:0] || in_ready !== 1'b0) idx_ok = 1'b0;
            if (churn) begin
                in_valid   = 1'($urandom_range(0, 1));
                in_key     = {$urandom, $urandom};
                in_data    = {$urandom, $urandom};
                in_decrypt = 1'($urandom_range(0, 1));
            end
            tick();
            edges++;
        end
        in_valid = 1'b0;
        check({name, " latency"}, edges, 16);
        check({name, " round sequence"}, idx_ok, 1);
        check({name, " out_data"}, out_data, want);
        check({name, " busy in DONE"}, busy, 0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            tick();
            check({name, " hold out_valid"}, out_valid, 1);
            check({name, " hold out_data"}, out_data, want);
            check({name, " hold in_ready"}, in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " release out_valid"}, out_valid, 0);
        check({name, " release in_ready"}, in_ready, 1);
    endtask

    typedef struct {
        logic [63:0] key;
        logic [63:0] data;
        logic        dec;
        logic [63:0] want;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int  n;
        bit  stale;
        logic [63:0] rk, rd;
        logic        rdec;

        vecs[0] = '{64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b0, 64'h85E813540F0AB405};
        vecs[1] = '{64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b1, 64'h0123456789ABCDEF};
        vecs[2] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
        vecs[3] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};

        // Reset state while rst is held.
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset round_idx", round_idx, 0);
        check("reset out_data", out_data, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reference model against the published vector.
        check("model vec0", des_model(vecs[0].key, vecs[0].data, vecs[0].dec), vecs[0].want);

        // Known-answer table: vec0 with 10 cycles of backpressure, vec1 with input churn.
        for (int i = 0; i < 4; i++)
            run_block(vecs[i].key, vecs[i].data, vecs[i].dec, vecs[i].want,
                      $sformatf("vec%0d", i), i == 1, (i == 0) ? 10 : 1);

        // Random blocks against the model.
        for (int i = 0; i < 20; i++) begin
            rk   = {$urandom, $urandom};
            rd   = {$urandom, $urandom};
            rdec = 1'($urandom_range(0, 1));
            run_block(rk, rd, rdec, des_model(rk, rd, rdec), $sformatf("rand%0d", i),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Reset in the middle of round 8 (round_idx = 7).
        in_valid = 1'b1; in_key = vecs[0].key; in_data = vecs[0].data; in_decrypt = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (round_idx !== 4'd7 && n < 20) begin
            tick();
            n++;
        end
        check("mid reset reached round 7", round_idx, 7);
        rst = 1'b1;
        #1;
        check("mid reset in_ready", in_ready, 1);
        check("mid reset out_valid", out_valid, 0);
        check("mid reset busy", busy, 0);
        check("mid reset out_data", out_data, 0);
        check("mid reset round_idx", round_idx, 0);
        tick(); tick();
        rst = 1'b0;
        stale = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        check("no stale output after reset", stale, 0);
        run_block(vecs[2].key, vecs[2].data, 1'b0, vecs[2].want, "after reset", 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, got timeout, want finish");
        $fatal(1, "watchdog expired");
    end
endmodule
